// File: rtl/alu_sequencial.sv
// Multi-cycle ALU for the EX stage: single-cycle arithmetic/logic ops plus
// bit-serial shifts, with a start/busy/done handshake.
module alu_sequencial #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         aluCtrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   resultado,
    output logic               zero,
    output logic               erro
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic [WIDTH-1:0]   resultado_q, resultado_d;
    logic               zero_q, zero_d;
    logic               erro_q, erro_d;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_err;

    always_comb begin
        comb_res = '0;
        comb_err = 1'b0;
        case (aluCtrl)
            OP_ADD:  comb_res = a + b;
            OP_SUB:  comb_res = a - b;
            OP_AND:  comb_res = a & b;
            OP_OR:   comb_res = a | b;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: comb_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        resultado_d = resultado_q;
        zero_d      = zero_q;
        erro_d      = erro_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (aluCtrl == OP_SLL || aluCtrl == OP_SRL) begin
                        acc_d   = b;
                        cnt_d   = shamt;
                        left_d  = (aluCtrl == OP_SLL);
                        state_d = SHIFT;
                    end else begin
                        resultado_d = comb_res;
                        zero_d      = (comb_res == '0);
                        erro_d      = comb_err;
                        state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                // One bit position per clock; the shift finishes on the edge that sees cnt == 0.
                if (cnt_q != '0) begin
                    acc_d = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    resultado_d = acc_q;
                    zero_d      = (acc_q == '0);
                    erro_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            resultado_q <= '0;
            zero_q      <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            resultado_q <= resultado_d;
            zero_q      <= zero_d;
            erro_q      <= erro_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign resultado = resultado_q;
    assign zero      = zero_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_alu_sequencial.sv
// Directed bench for alu_sequencial: vector table for single-cycle ops plus
// hand-written shift, back-to-back and reset-abort sequences.
module tb_alu_sequencial;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  aluCtrl;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        busy, done, zero, erro;
    logic [31:0] resultado;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencial #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .aluCtrl(aluCtrl),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .resultado(resultado), .zero(zero), .erro(erro)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        erro;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_shift(input logic [3:0] ctrl, input logic [31:0] bv,
                             input logic [4:0] sa, input logic [31:0] exp, input bit pulse);
        start = 1'b1; aluCtrl = ctrl; b = bv; shamt = sa;
        step();
        start = 1'b0;
        check("shift busy t0", {31'd0, busy}, 32'd1);
        check("shift done t0", {31'd0, done}, 32'd0);
        for (int i = 1; i <= int'(sa); i++) begin
            start   = pulse && (i == 3 || i == 10);
            aluCtrl = pulse ? 4'd0 : ctrl;
            b       = pulse ? 32'hFFFF_FFFF : bv;
            shamt   = pulse ? 5'd2 : sa;
            step();
            start = 1'b0;
            check("shift busy mid", {31'd0, busy}, 32'd1);
            check("shift done mid", {31'd0, done}, 32'd0);
        end
        step();
        check("shift done", {31'd0, done}, 32'd1);
        check("shift busy end", {31'd0, busy}, 32'd0);
        check("shift result", resultado, exp);
        check("shift zero", {31'd0, zero}, {31'd0, exp == 32'd0});
        check("shift erro", {31'd0, erro}, 32'd0);
        step();
        check("shift done pulse", {31'd0, done}, 32'd0);
        check("shift hold", resultado, exp);
    endtask

    initial begin
        vecs[0] = '{4'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{4'd1, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0};
        vecs[2] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[3] = '{4'd2, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0};
        vecs[4] = '{4'd3, 32'hA000_0005,  32'h0500_0030,  32'hA500_0035,  1'b0, 1'b0};
        vecs[5] = '{4'd6, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[6] = '{4'd6, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[7] = '{4'd9, 32'd8,          32'd9,          32'd0,          1'b1, 1'b1};
        vecs[8] = '{4'd1, 32'd2,          32'd5,          32'hFFFF_FFFD,  1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; aluCtrl = 4'd0; a = '0; b = '0; shamt = '0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset resultado", resultado, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd0);
        check("reset erro", {31'd0, erro}, 32'd0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            start = 1'b1; aluCtrl = vecs[i].ctrl; a = vecs[i].a; b = vecs[i].b;
            step();
            start = 1'b0;
            check($sformatf("vec%0d done", i), {31'd0, done}, 32'd1);
            check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d res", i), resultado, vecs[i].res);
            check($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d erro", i), {31'd0, erro}, {31'd0, vecs[i].erro});
            step();
            check($sformatf("vec%0d done low", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d hold", i), resultado, vecs[i].res);
        end

        // back-to-back: sub 3-3 then add wrap, done on consecutive cycles
        start = 1'b1; aluCtrl = 4'd0; a = 32'd5; b = 32'd7;
        step();
        aluCtrl = 4'd1; a = 32'd3; b = 32'd3;
        step();
        check("b2b done1", {31'd0, done}, 32'd1);
        check("b2b res1", resultado, 32'd0);
        check("b2b zero1", {31'd0, zero}, 32'd1);
        aluCtrl = 4'd0; a = 32'hFFFF_FFFF; b = 32'd1;
        step();
        start = 1'b0;
        check("b2b done2", {31'd0, done}, 32'd1);
        check("b2b res2", resultado, 32'd0);
        check("b2b zero2", {31'd0, zero}, 32'd1);
        step();
        check("b2b idle", {31'd0, done}, 32'd0);

        run_shift(4'd4, 32'd1,         5'd31, 32'h8000_0000, 1'b1);
        run_shift(4'd5, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0);
        run_shift(4'd5, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
        run_shift(4'd4, 32'h0000_00F0, 5'd28, 32'h0000_0000, 1'b0);
        run_shift(4'd5, 32'hF000_000F, 5'd3,  32'h1E00_0001, 1'b0);

        // reset mid-SHIFT: non-zero result first, then abort an sll
        start = 1'b1; aluCtrl = 4'd3; a = 32'h0000_1000; b = 32'd0;
        step();
        start = 1'b1; aluCtrl = 4'd4; b = 32'd1; shamt = 5'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        check("pre-reset res", resultado, 32'h0000_1000);
        #2 reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort res", resultado, 32'd0);
        check("abort zero", {31'd0, zero}, 32'd0);
        check("abort erro", {31'd0, erro}, 32'd0);
        step();
        #2 reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (done || busy) seen++;
            end
            check("no done after abort", seen, 32'd0);
        end
        start = 1'b1; aluCtrl = 4'd0; a = 32'd40; b = 32'd2;
        step();
        start = 1'b0;
        check("post-reset done", {31'd0, done}, 32'd1);
        check("post-reset res", resultado, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
